apb_gpio_completer: RTL
=======================

# apb_gpio_completer

APB completer that owns the GPIO register file: accepts APB setup/access transfers from the existing APB master and drives PREADY, PRDATA and PSLVERR back. It adds a two-flop input synchronizer, rising-edge interrupt capture and programmable wait states. It sits on the slave side of the APB bus, between the master and the 32-bit GPIO pad ring.

## Interface
- WIDTH, 32, GPIO port width and APB data width.
- PCLK  in  1  system clock, all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase marker.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  8  word index; only PADDR[7:0] values 0..6 are valid.
- PWDATA  in  WIDTH  write data.
- PSTRB  in  4  byte-lane write strobes.
- PRDATA  out  WIDTH  read data, valid when PREADY=1.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error, valid only when PREADY=1.
- i_port  in  WIDTH  asynchronous pad inputs.
- o_port  out  WIDTH  pad output values.
- o_oe  out  WIDTH  pad output enables.
- irq  out  1  level interrupt.

## Operation
- Registers (index: name, access):
  - 0: MODE, RW, bit = 1 open-drain.
  - 1: DIR, RW, bit = 1 output.
  - 2: OUT, RW.
  - 3: IN, RO; reads the synchronized i_port.
  - 4: IRQ_EN, RW.
  - 5: IRQ_STAT, W1C.
  - 6: WAIT, RW; only bits [3:0] are implemented, upper bits read 0.
- Pads:
  - Push-pull bit: o_port = OUT, o_oe = DIR.
  - Open-drain bit: o_port = 0, o_oe = DIR & ~OUT.
- Writes honour PSTRB per byte lane. PSTRB = 0 is a legal no-op with no error.
- Errors:
  - PSLVERR = 1 for any access with PADDR > 6.
  - PSLVERR = 1 for a write to index 3 (IN).
  - An errored transfer changes no register.
  - An errored read returns PRDATA = 0.
- Input path:
  - Synchronizer: sync1 <= i_port, sync2 <= sync1; edge_q <= sync2.
  - A rising edge on bit n (sync2 & ~edge_q) sets IRQ_STAT[n].
  - If a W1C clear and a new edge hit the same bit in the same cycle, set wins.
- irq = |(IRQ_STAT & IRQ_EN), registered (one cycle after the status/enable change).
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when PSEL & ~PENABLE. On that edge latch PADDR, PWRITE, PSTRB, PWDATA and WAIT[3:0] into wait_q, and clear counter cnt.
  - ACCESS: cnt increments each cycle while cnt < wait_q.
  - PREADY = (state == ACCESS) & PENABLE & (cnt == wait_q).
  - ACCESS -> IDLE on the PREADY cycle.
  - ACCESS with PSEL = 0 (protocol violation) -> IDLE, no register effect.
- Back-to-back transfers: the next setup phase is sampled in IDLE the cycle after PREADY, so there are no dead cycles beyond APB's own setup phase.
- Write commit: on the rising edge where PREADY = 1. A write to WAIT applies from the next transfer.

## Timing
- Reset values: all registers 0, sync/edge flops 0, state IDLE, cnt 0, PREADY 0, PSLVERR 0, PRDATA 0, o_port 0, o_oe 0, irq 0.
- Reset asserted mid-transfer: next edge forces IDLE and clears all registers. The pending write is discarded; PREADY is 0 that cycle.
- Transfer latency with WAIT = N: setup cycle, then N+1 access cycles. PREADY is high on access cycle N+1. N = 0 gives the standard 2-cycle APB transfer.
- PRDATA and PSLVERR are combinational from latched address and register state during ACCESS, and 0 in IDLE.
- i_port to IN visibility: 2 cycles.
- i_port rising edge to IRQ_STAT set: 3 cycles. To irq (if enabled): 4 cycles.
- Register write to o_port/o_oe change: visible the cycle after the PREADY edge.
- PREADY/PSLVERR are low whenever the FSM is in IDLE.

## Test plan
- Reset, then write DIR = FFFFFFFF, OUT = 0000000F, MODE = 0, WAIT = 0 -> each transfer has PREADY on its first access cycle; o_port = 0000000F, o_oe = FFFFFFFF.
- MODE = FFFFFFFF with OUT = 0000000F, DIR = FFFFFFFF -> o_port = 0, o_oe = FFFFFFF0.
- DIR = 0, drive i_port = 0000000A, read index 3 -> PRDATA = 0000000A, PSLVERR = 0. Write index 3 -> PSLVERR = 1 and IN is unchanged.
- IRQ_EN = 1, i_port bit0 rises -> IRQ_STAT = 1 after 3 cycles, irq = 1 after 4. W1C of 1 in the same cycle as a new edge leaves the bit set.
- WAIT = 3, then read OUT -> PREADY on the 4th access cycle. Write PSTRB = 0010 with PWDATA = AABBCCDD to OUT = 0 -> OUT = 0000CC00. Read index 9 -> PSLVERR = 1, PRDATA = 0.
- Assert PRESET during the access phase of a write to OUT -> OUT stays 0, PREADY = 0, FSM in IDLE; the next transfer completes normally.

Source files
------------

// File: rtl/apb_gpio_completer_if.sv
// APB bus bundle between the existing APB master and the GPIO completer.
// Valid/ready: a transfer completes on the rising edge where PSEL, PENABLE and PREADY are all high.
interface apb_gpio_completer_if #(
  parameter int WIDTH = 32
);
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [7:0]         PADDR;
  logic [WIDTH-1:0]   PWDATA;
  logic [WIDTH/8-1:0] PSTRB;
  logic [WIDTH-1:0]   PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_completer.sv
// APB completer owning the GPIO register file: pad drive, input synchronizer,
// rising-edge interrupt capture and programmable access wait states.
module apb_gpio_completer #(
  parameter int WIDTH = 32
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_gpio_completer_if.slave  bus,
  input  logic [WIDTH-1:0]     i_port,
  output logic [WIDTH-1:0]     o_port,
  output logic [WIDTH-1:0]     o_oe,
  output logic                 irq,
  output logic                 o_dbg_state
);

  localparam logic [7:0] A_MODE     = 8'd0;
  localparam logic [7:0] A_DIR      = 8'd1;
  localparam logic [7:0] A_OUT      = 8'd2;
  localparam logic [7:0] A_IN       = 8'd3;
  localparam logic [7:0] A_IRQ_EN   = 8'd4;
  localparam logic [7:0] A_IRQ_STAT = 8'd5;
  localparam logic [7:0] A_WAIT     = 8'd6;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_latch;
  logic               w_cnt_inc;

  logic [3:0]         r_cnt;
  logic [3:0]         r_wait_q;
  logic [7:0]         r_addr;
  logic               r_write;
  logic [WIDTH/8-1:0] r_strb;
  logic [WIDTH-1:0]   r_wdata;

  logic [WIDTH-1:0]   r_mode;
  logic [WIDTH-1:0]   r_dir;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_irq_en;
  logic [WIDTH-1:0]   r_irq_stat;
  logic [3:0]         r_wait;

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [WIDTH-1:0]   r_edge_q;
  logic               r_irq;

  logic               w_pready;
  logic               w_err;
  logic               w_wr;
  logic [WIDTH-1:0]   w_mask;
  logic [WIDTH-1:0]   w_rise;
  logic [WIDTH-1:0]   w_clr;
  logic [WIDTH-1:0]   w_rdata;

  // PRESET gates PREADY so a transfer caught by reset never reports completion.
  assign w_pready = (r_state == ST_ACCESS) & bus.PSEL & bus.PENABLE &
                    (r_cnt == r_wait_q) & ~PRESET;
  assign w_err    = (r_addr > A_WAIT) | (r_write & (r_addr == A_IN));
  assign w_wr     = w_pready & r_write & ~w_err;
  assign w_rise   = r_sync2 & ~r_edge_q;
  assign w_clr    = (w_wr && r_addr == A_IRQ_STAT) ? (r_wdata & w_mask) : '0;

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < WIDTH/8; b++) begin
      w_mask[b*8 +: 8] = {8{r_strb[b]}};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          w_state_nxt = ST_ACCESS;
          w_latch     = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!bus.PSEL || w_pready) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt < r_wait_q) begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_wait_q <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_strb   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_addr   <= bus.PADDR;
        r_write  <= bus.PWRITE;
        r_strb   <= bus.PSTRB;
        r_wdata  <= bus.PWDATA;
        r_wait_q <= r_wait;
        r_cnt    <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_mode     <= '0;
      r_dir      <= '0;
      r_out      <= '0;
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_wait     <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_edge_q   <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_sync1  <= i_port;
      r_sync2  <= r_sync1;
      r_edge_q <= r_sync2;
      if (w_wr && r_addr == A_MODE)   r_mode   <= (r_mode   & ~w_mask) | (r_wdata & w_mask);
      if (w_wr && r_addr == A_DIR)    r_dir    <= (r_dir    & ~w_mask) | (r_wdata & w_mask);
      if (w_wr && r_addr == A_OUT)    r_out    <= (r_out    & ~w_mask) | (r_wdata & w_mask);
      if (w_wr && r_addr == A_IRQ_EN) r_irq_en <= (r_irq_en & ~w_mask) | (r_wdata & w_mask);
      if (w_wr && r_addr == A_WAIT)   r_wait   <= (r_wait & ~w_mask[3:0]) | (r_wdata[3:0] & w_mask[3:0]);
      // OR-ing the new edges after the clear makes a simultaneous edge win.
      r_irq_stat <= (r_irq_stat & ~w_clr) | w_rise;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (r_addr)
      A_MODE:     w_rdata = r_mode;
      A_DIR:      w_rdata = r_dir;
      A_OUT:      w_rdata = r_out;
      A_IN:       w_rdata = r_sync2;
      A_IRQ_EN:   w_rdata = r_irq_en;
      A_IRQ_STAT: w_rdata = r_irq_stat;
      A_WAIT:     w_rdata = {{(WIDTH-4){1'b0}}, r_wait};
      default:    w_rdata = '0;
    endcase
  end

  assign bus.PRDATA  = (r_state == ST_ACCESS && !r_write && !w_err) ? w_rdata : '0;
  assign bus.PREADY  = w_pready;
  assign bus.PSLVERR = w_pready & w_err;

  assign o_port      = r_out & ~r_mode;
  assign o_oe        = r_dir & ~(r_mode & r_out);
  assign irq         = r_irq;
  assign o_dbg_state = (r_state == ST_ACCESS);

endmodule
